lsu_align: RTL and testbench

LSU_ALIGN -- requirements
Module: lsu_align

---
 rtl/lsu_align_pkg.sv | 84 ++++++++
 rtl/lsu_align_load_ext.sv | 33 +++
 rtl/lsu_align.sv | 146 ++++++++++++++
 tb/tb_lsu_align.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_align_pkg.sv
// Shared definitions for the load/store alignment unit: size codes, FSM states,
// captured-request payload and lane helper functions.
package lsu_align_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned LANES  = XLEN / 8;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned LANE_W = 2;

    localparam logic [SIZE_W-1:0] LSU_SIZE_B = 2'd0;
    localparam logic [SIZE_W-1:0] LSU_SIZE_H = 2'd1;
    localparam logic [SIZE_W-1:0] LSU_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic              we;
        logic [SIZE_W-1:0] size;
        logic              is_unsigned;
        logic [LANE_W-1:0] addr_lo;
    } lsu_req_t;

    // Size code 3 is an alias for word.
    function automatic logic [SIZE_W-1:0] lsu_norm_size(input logic [SIZE_W-1:0] size);
        logic [SIZE_W-1:0] r;
        r = size;
        if (size == 2'b11) r = LSU_SIZE_W;
        return r;
    endfunction

    function automatic logic lsu_misaligned(input logic [SIZE_W-1:0] size,
                                            input logic [LANE_W-1:0] addr_lo);
        logic r;
        r = 1'b0;
        case (size)
            LSU_SIZE_B: r = 1'b0;
            LSU_SIZE_H: r = addr_lo[0];
            default:    r = |addr_lo;
        endcase
        return r;
    endfunction

    function automatic logic [LANE_W-1:0] lsu_align_lo(input logic [SIZE_W-1:0] size,
                                                       input logic [LANE_W-1:0] addr_lo);
        logic [LANE_W-1:0] r;
        r = addr_lo;
        case (size)
            LSU_SIZE_B: r = addr_lo;
            LSU_SIZE_H: r = {addr_lo[1], 1'b0};
            default:    r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [LANES-1:0] lsu_store_we(input logic [SIZE_W-1:0] size,
                                                      input logic [LANE_W-1:0] addr_lo);
        logic [LANES-1:0] r;
        r = '1;
        case (size)
            LSU_SIZE_B: r = LANES'(1) << addr_lo;
            LSU_SIZE_H: r = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    r = '1;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] lsu_store_data(input logic [SIZE_W-1:0] size,
                                                       input logic [XLEN-1:0]   wdata);
        logic [XLEN-1:0] r;
        r = wdata;
        case (size)
            LSU_SIZE_B: r = {4{wdata[7:0]}};
            LSU_SIZE_H: r = {2{wdata[15:0]}};
            default:    r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align_load_ext.sv
// Combinational load lane selection and sign/zero extension (little-endian lanes).
module lsu_load_ext
    import lsu_align_pkg::*;
(
    input  logic [SIZE_W-1:0] size_i,
    input  logic              unsigned_i,
    input  logic [LANE_W-1:0] addr_i,
    input  logic [XLEN-1:0]   word_i,
    output logic [XLEN-1:0]   data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        half_sel = word_i[15:0];
        data_o   = word_i;
        case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        if (addr_i[1]) half_sel = word_i[31:16];
        case (size_i)
            LSU_SIZE_B: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            LSU_SIZE_H: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default:    data_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: one request at a time to a synchronous data RAM.
// Build option LSU_MISALIGN_EXC_EN: misaligned half/word accesses return resp_exc
// without touching memory; otherwise the low address bits are forced aligned.
module lsu_align
    import lsu_align_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [SIZE_W-1:0] req_size_i,
    input  logic              req_unsigned_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_exc_o,
    output logic              mem_en_o,
    output logic [LANES-1:0]  mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    lsu_state_e       state_q,      state_d;
    lsu_req_t         req_q,        req_d;
    logic             req_ready_q,  req_ready_d;
    logic             mem_en_q,     mem_en_d;
    logic [LANES-1:0] mem_we_q,     mem_we_d;
    logic [XLEN-1:0]  mem_addr_q,   mem_addr_d;
    logic [XLEN-1:0]  mem_wdata_q,  mem_wdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_exc_q,   resp_exc_d;
    logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;

    logic [SIZE_W-1:0] size_n;
    logic [LANE_W-1:0] lo_n;
    logic              exc_n;
    logic [XLEN-1:0]   load_data;

    lsu_load_ext u_load_ext (
        .size_i     (req_q.size),
        .unsigned_i (req_q.is_unsigned),
        .addr_i     (req_q.addr_lo),
        .word_i     (mem_rdata_i),
        .data_o     (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_we_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_exc_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_exc_q   <= resp_exc_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Outputs are registered on the edge that enters the state they belong to.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        mem_en_d     = 1'b0;
        mem_we_d     = '0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_exc_d   = 1'b0;
        resp_rdata_d = '0;
        size_n       = lsu_norm_size(req_size_i);
`ifdef LSU_MISALIGN_EXC_EN
        lo_n         = req_addr_i[1:0];
        exc_n        = lsu_misaligned(size_n, req_addr_i[1:0]);
`else
        lo_n         = lsu_align_lo(size_n, req_addr_i[1:0]);
        exc_n        = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    req_d = '{we: req_we_i, size: size_n,
                              is_unsigned: req_unsigned_i, addr_lo: lo_n};
                    if (exc_n) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = 1'b1;
                    end else begin
                        state_d     = ST_MEM;
                        mem_en_d    = 1'b1;
                        mem_addr_d  = {req_addr_i[XLEN-1:2], 2'b00};
                        mem_wdata_d = '0;
                        if (req_we_i) begin
                            mem_we_d    = lsu_store_we(size_n, lo_n);
                            mem_wdata_d = lsu_store_data(size_n, req_wdata_i);
                        end
                    end
                end
            end
            ST_MEM: begin
                if (req_q.we) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    assign req_ready_o  = req_ready_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_exc_o   = resp_exc_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align: byte-granular memory reference model, RAM model
// and a negedge monitor comparing every memory access and response.
module tb_lsu_align;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_exc, mem_en;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    lsu_align dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_exc_o     (resp_exc),
        .mem_en_o       (mem_en),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        int          lat;
        int          acc_cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          acc_cyc;
    } mem_t;

    resp_t resp_q[$];
    mem_t  mem_q[$];

    int checks, errors;
    int cyc, issued, acc_seen, tmo_cnt, tmo_seen;
    bit done, final_done, mon_busy;

    logic [31:0] ram     [16];
    logic [31:0] ref_mem [16];
    logic        poke_en;
    logic [3:0]  poke_idx;
    logic [31:0] poke_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rst_n && req_valid && req_ready) acc_seen <= acc_seen + 1;

    // Synchronous RAM: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (poke_en) begin
            ram[poke_idx] <= poke_data;
        end else if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) ram[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            mem_rdata <= ram[mem_addr[5:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_resp_rdata", resp_rdata, 32'd0);
            chk("rst_resp_exc", 32'(resp_exc), 32'd0);
            resp_q.delete();
            mem_q.delete();
        end else begin
            mon_busy = (resp_q.size() != 0) && (cyc >= resp_q[0].acc_cyc);
            chk("req_ready", 32'(req_ready), 32'(!mon_busy));
            if (mem_en) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected", 32'(mem_en), 32'd0);
                end else begin
                    mem_t m;
                    m = mem_q.pop_front();
                    chk("mem_timing", 32'(cyc), 32'(m.acc_cyc));
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    if (m.we != 4'd0) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end else begin
                chk("mem_we_idle", 32'(mem_we), 32'd0);
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_exc", 32'(resp_exc), 32'(r.exc));
                    chk("resp_latency", 32'(cyc - r.acc_cyc + 1), 32'(r.lat));
                end
            end
            if (tmo_cnt != tmo_seen) begin
                chk("stim_ready_timeout", 32'(tmo_cnt), 32'(tmo_seen));
                tmo_seen = tmo_cnt;
            end
            if (done && !final_done) begin
                chk("accept_count", 32'(acc_seen), 32'(issued));
                chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
                chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
                final_done = 1'b1;
            end
        end
    end

    // Reference model: byte-addressed little-endian memory, plain arithmetic.
    task automatic push_expect(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
        int          nbytes, lane, idx;
        longint      v, mask, rep;
        logic [31:0] a;
        resp_t       r;
        mem_t        m;
        nbytes    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        r.acc_cyc = cyc + 1;
        r.exc     = 1'b0;
        r.rdata   = 32'd0;
        r.lat     = 2;
`ifdef LSU_MISALIGN_EXC_EN
        if ((addr % 32'(nbytes)) != 32'd0) begin
            r.exc = 1'b1;
            r.lat = 1;
            resp_q.push_back(r);
            return;
        end
`endif
        a         = addr - (addr % 32'(nbytes));
        idx       = int'(a[5:2]);
        lane      = int'(a[1:0]);
        mask      = (64'd1 << (8 * nbytes)) - 64'd1;
        m.acc_cyc = cyc + 1;
        m.addr    = a & 32'hFFFF_FFFC;
        m.we      = 4'd0;
        m.wdata   = 32'd0;
        if (we) begin
            rep     = (nbytes == 1) ? 64'h0101_0101 : (nbytes == 2) ? 64'h0001_0001 : 64'd1;
            m.wdata = 32'((longint'(wdata) & mask) * rep);
            for (int b = lane; b < lane + nbytes; b++) begin
                m.we[b] = 1'b1;
                ref_mem[idx][8*b +: 8] = wdata[8*(b-lane) +: 8];
            end
            r.lat = 2;
        end else begin
            v = longint'(ref_mem[idx] >> (8 * lane)) & mask;
            if (!uns && v >= (64'd1 << (8 * nbytes - 1))) v = v - (64'd1 << (8 * nbytes));
            r.rdata = 32'(v);
            r.lat   = 3;
        end
        mem_q.push_back(m);
        resp_q.push_back(r);
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        poke_en      = 1'b1;
        poke_idx     = 4'(idx);
        poke_data    = data;
        ref_mem[idx] = data;
        @(negedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1 n++;
        end
        if (!req_ready) tmo_cnt++;
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
    endtask

    // Called just after a negedge; returns just after the negedge following accept.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        wait_ready();
        if (!req_ready) return;
        push_expect(we, size, uns, addr, wdata);
        issued++;
        drive(we, size, uns, addr, wdata);
        @(negedge clk);
        #1;
        if (hold) drive(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        else req_valid = 1'b0;
    endtask

    task automatic abort_load(input logic [31:0] addr);
        wait_ready();
        if (!req_ready) return;
        push_expect(1'b0, 2'd2, 1'b0, addr, 32'd0);
        issued++;
        drive(1'b0, 2'd2, 1'b0, addr, 32'd0);
        @(negedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        poke_en = 1'b0;
        poke_idx = 4'd0;
        poke_data = 32'd0;
        for (int i = 0; i < 16; i++) poke(i, $urandom);
        @(negedge clk);
        #1 rst_n = 1'b1;

        poke(0, 32'h80FF_1234);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 1'b0);
        poke(0, 32'h8001_7FFF);
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_1002, 32'd0, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h0000_00AB, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'd0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_3002, 32'h1234_5678, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_1006, 32'hCAFE_BEEF, 1'b0);
        do_req(1'b0, 2'd3, 1'b1, 32'h0000_4004, 32'd0, 1'b0);

        abort_load(32'h0000_1008);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_1008, 32'd0, 1'b0);

        for (int i = 0; i < 8; i++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, i < 7);

        for (int i = 0; i < 300; i++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                   (i < 299) && ($urandom_range(0, 1) == 1));

        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 done = 1'b1;
        n = 0;
        while (!final_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!final_done) begin
            $display("FAIL final_check: monitor never completed its end-of-run checks");
            $fatal(1, "monitor stalled");
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
